// File: rtl/vl_pipe_catch_fifo.sv
// Credit-managed catch buffer behind a fixed-latency, non-stallable pipe.
// Credits cover words in flight, so a well-behaved upstream never overruns the FIFO.
module vl_pipe_catch_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             issue,
  output logic             crd_avail,
  input  logic             in_vld,
  input  logic [DW-1:0]    in_data,
  output logic             out_vld,
  output logic [DW-1:0]    out_data,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] crd_cnt,
  output logic             err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_crd;
  logic             r_err;

  logic             w_clear;
  logic             w_pop;
  logic             w_full;
  logic             w_wr_en;
  logic             w_drop;
  logic             w_issue_ok;
  logic             w_issue_err;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_crd_next;

  assign w_clear = reset | clr;
  assign w_pop   = (r_count != '0) & out_rdy;
  assign w_full  = (r_count == DEPTH_C);
  // A full FIFO still accepts a word if the head leaves in the same cycle.
  assign w_wr_en = in_vld & (~w_full | w_pop);
  assign w_drop  = in_vld & w_full & ~w_pop;

  // An issue at zero credits is only legal when a pop frees a slot this cycle.
  assign w_issue_ok  = issue & ((r_crd != '0) | w_pop);
  assign w_issue_err = issue & (r_crd == '0) & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_crd_next = r_crd;
    case ({w_issue_ok, w_pop})
      2'b10:   w_crd_next = r_crd - 1'b1;
      2'b01:   w_crd_next = r_crd + 1'b1;
      default: w_crd_next = r_crd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_crd    <= DEPTH_C;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_crd   <= w_crd_next;
      r_err   <= r_err | w_drop | w_issue_err;
    end
  end

  // Storage is never cleared; only the pointers and counters are.
  always_ff @(posedge clk) begin
    if (w_wr_en && !w_clear) r_mem[r_wr_ptr] <= in_data;
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_vld   = (r_count != '0);
  assign crd_avail = (r_crd != '0);
  assign count     = r_count;
  assign crd_cnt   = r_crd;
  assign err       = r_err;

endmodule
